// File: rtl/dmem_bus_pkg.sv
// Shared types for the data-memory bus interface.
// Request bundle, FSM state encoding and bus constants.
package dmem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] adr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  byteen;
   } dmem_req_t;

   localparam logic [3:0]  BYTE_EN_NONE  = 4'b0000;
   localparam logic [31:0] ADR_WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_timeout.sv
// Saturating cycle counter bounding one bus access.
// expired is high during the LIMIT-th counted cycle.
module dmem_timeout #(
   parameter int LIMIT = 255,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != W'(LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt >= W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: one load/store per request,
// valid/ready request channel, valid-only response channel.
module dmem_bus_if
   import dmem_bus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] IEUAdr,
   input  logic [31:0] WriteData,
   input  logic [3:0]  WriteByteEn,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Done,
   output logic        Fault,
   output logic        BusReqValid,
   input  logic        BusReqReady,
   output logic [31:0] BusAdr,
   output logic        BusWrite,
   output logic [31:0] BusWData,
   output logic [3:0]  BusByteEn,
   input  logic        BusRspValid,
   input  logic [31:0] BusRData,
   input  logic        BusErr
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   dmem_state_t state, state_n;
   dmem_req_t   req_q;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic        done_q;

   logic load_req;
   logic cnt_clr;
   logic cnt_en;
   logic capture;
   logic tmo;
   logic expired;

   dmem_timeout #(
      .LIMIT (TIMEOUT),
      .W     (TO_W)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (expired)
   );

   // A response in the expiring cycle still wins; real data beats a fault.
   always_comb begin
      state_n  = state;
      load_req = 1'b0;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      capture  = 1'b0;
      tmo      = 1'b0;
      unique case (state)
         IDLE: begin
            if (MemReq) begin
               load_req = 1'b1;
               cnt_clr  = 1'b1;
               state_n  = REQ;
            end
         end
         REQ: begin
            cnt_en = 1'b1;
            if (expired) begin
               tmo     = 1'b1;
               state_n = DONE;
            end else if (BusReqReady) begin
               state_n = RESP;
            end
         end
         RESP: begin
            cnt_en = 1'b1;
            if (BusRspValid) begin
               capture = 1'b1;
               state_n = DONE;
            end else if (expired) begin
               tmo     = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q <= '0;
      end else if (load_req) begin
         req_q.adr    <= IEUAdr & ADR_WORD_MASK;
         req_q.write  <= MemWrite;
         req_q.wdata  <= WriteData;
         req_q.byteen <= MemWrite ? WriteByteEn : BYTE_EN_NONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         fault_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state_n == DONE);
         if (capture) begin
            rdata_q <= BusRData;
            fault_q <= BusErr;
         end else if (tmo) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
         end else if (state == DONE) begin
            fault_q <= 1'b0;
         end
      end
   end

   assign Stall = ((state == IDLE) && MemReq)
                || (state == REQ)
                || (state == RESP);

   assign BusReqValid = (state == REQ);
   assign BusAdr      = req_q.adr;
   assign BusWrite    = req_q.write;
   assign BusWData    = req_q.wdata;
   assign BusByteEn   = req_q.byteen;

   assign ReadData = rdata_q;
   assign Fault    = fault_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if (TIMEOUT=8).
// Core and memory sides are driven by hand, cycle by cycle.
module tb_dmem_bus_if;

   logic        clk;
   logic        reset;
   logic        MemReq;
   logic        MemWrite;
   logic [31:0] IEUAdr;
   logic [31:0] WriteData;
   logic [3:0]  WriteByteEn;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Done;
   logic        Fault;
   logic        BusReqValid;
   logic        BusReqReady;
   logic [31:0] BusAdr;
   logic        BusWrite;
   logic [31:0] BusWData;
   logic [3:0]  BusByteEn;
   logic        BusRspValid;
   logic [31:0] BusRData;
   logic        BusErr;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_bus_if #(
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .MemReq      (MemReq),
      .MemWrite    (MemWrite),
      .IEUAdr      (IEUAdr),
      .WriteData   (WriteData),
      .WriteByteEn (WriteByteEn),
      .ReadData    (ReadData),
      .Stall       (Stall),
      .Done        (Done),
      .Fault       (Fault),
      .BusReqValid (BusReqValid),
      .BusReqReady (BusReqReady),
      .BusAdr      (BusAdr),
      .BusWrite    (BusWrite),
      .BusWData    (BusWData),
      .BusByteEn   (BusByteEn),
      .BusRspValid (BusRspValid),
      .BusRData    (BusRData),
      .BusErr      (BusErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait load; returns in the DONE cycle with MemReq dropped.
   task automatic load_access(input logic [31:0] adr,
                              input logic [31:0] rd,
                              input logic        err);
      MemReq   = 1'b1;
      MemWrite = 1'b0;
      IEUAdr   = adr;
      step();
      BusReqReady = 1'b1;
      step();
      BusReqReady = 1'b0;
      BusRspValid = 1'b1;
      BusRData    = rd;
      BusErr      = err;
      step();
      BusRspValid = 1'b0;
      BusErr      = 1'b0;
      MemReq      = 1'b0;
   endtask

   initial begin
      int n;
      int sd;
      int hs;
      int nd;
      int d1;
      int d2;
      int vdone;
      logic hs_prev;
      logic [31:0] rd2;

      reset       = 1'b0;
      MemReq      = 1'b0;
      MemWrite    = 1'b0;
      IEUAdr      = '0;
      WriteData   = '0;
      WriteByteEn = '0;
      BusReqReady = 1'b0;
      BusRspValid = 1'b0;
      BusRData    = '0;
      BusErr      = 1'b0;

      #13;
      chk("rst_valid", BusReqValid, 0);
      chk("rst_done", Done, 0);
      chk("rst_fault", Fault, 0);
      chk("rst_rdata", ReadData, 0);
      chk("rst_stall", Stall, 0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // load, zero-wait
      MemReq   = 1'b1;
      MemWrite = 1'b0;
      IEUAdr   = 32'h0000_1006;
      #1;
      chk("ld_stall0", Stall, 1);
      chk("ld_valid0", BusReqValid, 0);
      step();
      chk("ld_valid1", BusReqValid, 1);
      chk("ld_adr", BusAdr, 32'h0000_1004);
      chk("ld_be", BusByteEn, 4'b0000);
      chk("ld_wr", BusWrite, 0);
      chk("ld_stall1", Stall, 1);
      BusReqReady = 1'b1;
      step();
      BusReqReady = 1'b0;
      chk("ld_valid2", BusReqValid, 0);
      chk("ld_stall2", Stall, 1);
      chk("ld_done2", Done, 0);
      BusRspValid = 1'b1;
      BusRData    = 32'hDEAD_BEEF;
      step();
      BusRspValid = 1'b0;
      chk("ld_done3", Done, 1);
      chk("ld_rdata", ReadData, 32'hDEAD_BEEF);
      chk("ld_fault", Fault, 0);
      chk("ld_stall3", Stall, 0);
      MemReq = 1'b0;
      step();
      chk("ld_done4", Done, 0);

      // store with 5 cycles of backpressure
      MemReq      = 1'b1;
      MemWrite    = 1'b1;
      IEUAdr      = 32'h0000_2000;
      WriteData   = 32'h0000_AB00;
      WriteByteEn = 4'b0010;
      step();
      IEUAdr      = 32'hFFFF_FFFF;
      WriteData   = 32'h5555_5555;
      WriteByteEn = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         chk("st_valid", BusReqValid, 1);
         chk("st_adr", BusAdr, 32'h0000_2000);
         chk("st_wdata", BusWData, 32'h0000_AB00);
         chk("st_be", BusByteEn, 4'b0010);
         chk("st_wr", BusWrite, 1);
         step();
      end
      BusReqReady = 1'b1;
      step();
      BusReqReady = 1'b0;
      BusRspValid = 1'b1;
      BusRData    = 32'h0BAD_0001;
      step();
      BusRspValid = 1'b0;
      MemReq      = 1'b0;
      MemWrite    = 1'b0;
      chk("st_done", Done, 1);
      chk("st_fault", Fault, 0);
      step();

      // bus error, then a clean access
      load_access(32'h0000_5008, 32'hCAFE_F00D, 1'b1);
      chk("err_done", Done, 1);
      chk("err_fault", Fault, 1);
      step();
      load_access(32'h0000_500C, 32'h1234_5678, 1'b0);
      chk("clean_done", Done, 1);
      chk("clean_fault", Fault, 0);
      chk("clean_rdata", ReadData, 32'h1234_5678);
      step();

      // timeout: no ready ever
      MemReq   = 1'b1;
      MemWrite = 1'b0;
      IEUAdr   = 32'h0000_4000;
      step();
      n = 0;
      while (!Done && n < 20) begin
         step();
         n++;
      end
      chk("to_lat", n, 8);
      chk("to_done", Done, 1);
      chk("to_fault", Fault, 1);
      chk("to_rdata", ReadData, 0);
      chk("to_valid", BusReqValid, 0);
      MemReq = 1'b0;
      step();
      step();
      step();
      BusRspValid = 1'b1;
      BusRData    = 32'hBAD0_BAD0;
      step();
      BusRspValid = 1'b0;
      sd = 0;
      for (int i = 0; i < 4; i++) begin
         if (Done) sd++;
         step();
      end
      chk("stray_done", sd, 0);
      chk("stray_rdata", ReadData, 0);
      chk("stray_stall", Stall, 0);

      // back-to-back accesses with MemReq held high
      MemReq   = 1'b1;
      MemWrite = 1'b0;
      IEUAdr   = 32'h0000_3000;
      hs = 0;
      nd = 0;
      d1 = 0;
      d2 = 0;
      vdone = 0;
      hs_prev = 1'b0;
      rd2 = '0;
      for (int c = 0; c < 12; c++) begin
         BusRspValid = hs_prev;
         BusRData    = 32'h100 + c;
         hs_prev     = 1'b0;
         if (Done) begin
            nd++;
            if (BusReqValid) vdone++;
            if (nd == 1) d1 = c;
            else begin
               d2  = c;
               rd2 = ReadData;
            end
            IEUAdr = 32'h0000_3004;
            if (nd == 2) MemReq = 1'b0;
         end
         BusReqReady = BusReqValid;
         if (BusReqValid) begin
            hs++;
            hs_prev = 1'b1;
         end
         step();
      end
      BusRspValid = 1'b0;
      BusReqReady = 1'b0;
      chk("b2b_reqs", hs, 2);
      chk("b2b_dones", nd, 2);
      chk("b2b_gap", d2 - d1, 4);
      chk("b2b_vdone", vdone, 0);
      chk("b2b_rdata", rd2, 32'h106);

      // reset during RESP
      MemReq   = 1'b1;
      MemWrite = 1'b0;
      IEUAdr   = 32'h0000_6000;
      step();
      BusReqReady = 1'b1;
      step();
      BusReqReady = 1'b0;
      MemReq      = 1'b0;
      chk("rr_stall_pre", Stall, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("rr_valid", BusReqValid, 0);
      chk("rr_stall", Stall, 0);
      chk("rr_done", Done, 0);
      chk("rr_rdata", ReadData, 0);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("rr_idle_valid", BusReqValid, 0);
      chk("rr_idle_stall", Stall, 0);
      load_access(32'h0000_6004, 32'h0A0B_0C0D, 1'b0);
      chk("rr_new_done", Done, 1);
      chk("rr_new_rdata", ReadData, 32'h0A0B_0C0D);
      chk("rr_new_fault", Fault, 0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
